scoreboard_regfile: RTL
=======================

# scoreboard_regfile

Parametrised integer register file with a per-register busy scoreboard, combinational read ports with optional write bypass, and a reservation handshake for in-flight destination registers. It replaces the single-issue two-read register file in the core. It lets a pipelined or multi-cycle execute stage detect RAW and WAW hazards without external tracking. Register 0 is hardwired to zero and never becomes busy.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, ≥ 2).
- NREAD, 2, number of read ports (1–4).
- BYPASS, 1, 1 = a read of the register being written this cycle returns `wb_data`; 0 = returns the stored value.
- AW, $clog2(NREGS), register address width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rd_addr  input  NREAD*AW  read addresses, port i at [i*AW +: AW].
- rd_data  output  NREAD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  output  NREAD  port i's register has a reservation outstanding.
- res_valid  input  1  request to reserve `res_rd` as a destination.
- res_rd  input  AW  register to reserve.
- res_accept  output  1  reservation taken this cycle.
- wb_valid  input  1  writeback strobe.
- wb_rd  input  AW  writeback destination.
- wb_data  input  XLEN  writeback value.
- pending_count  output  AW+1  number of currently busy registers.
- wb_error  output  1  sticky: a writeback targeted a non-busy, non-zero register.

## Operation
- Storage: NREGS×XLEN array plus an NREGS-bit `busy` vector. Register 0 always reads 0, and writes to it are discarded.
- Read, per port i (combinational):
  - rd_data = 0 if the address is 0.
  - Otherwise, if BYPASS=1, wb_valid=1 and wb_rd equals the address: rd_data = wb_data.
  - Otherwise rd_data = the stored value.
- rd_busy (per port): busy[addr] & ~(BYPASS & wb_valid & wb_rd==addr & ~(res_accept & res_rd==addr)).
- Reservation: res_accept = res_valid & (res_rd==0 | ~busy[res_rd] | (wb_valid & wb_rd==res_rd)).
  - Reserving register 0 is accepted but sets nothing.
  - A request refused for WAW (register still busy) must be held by the requester until accepted. No state changes on refusal.
- Writeback: when wb_valid and wb_rd≠0, the array entry is written and busy[wb_rd] cleared.
  - If busy[wb_rd] was 0, the data is still written and wb_error sets.
  - wb_error clears only on reset.
- Same-register reserve and writeback in one cycle: the data is written, and busy stays 1 (the new reservation wins).
- pending_count = popcount(busy), registered. It is updated by +1 per accepted non-zero reservation and −1 per writeback clearing a set bit, with both applied in one cycle. Range is 0..NREGS−1 and it never wraps.

## Timing
- Reset asserted (asynchronous): all registers 0, busy all 0, pending_count 0, wb_error 0.
  - Outputs: rd_data 0 for all ports, rd_busy 0, res_accept 0 while in reset.
  - Deassertion is synchronised externally; the first active edge after release may write.
- Reset mid-operation discards all outstanding reservations. Writebacks arriving afterward set wb_error.
- Read latency 0 cycles (combinational from rd_addr, wb_* and state).
- Write latency: value is visible through the array on the cycle after the wb_valid edge; with BYPASS=1 it is also visible in the same cycle.
- res_accept is combinational in the same cycle as res_valid. busy is set at that clock edge, and rd_busy reflects it from the next cycle.
- busy clear is visible the cycle after writeback (same cycle through the rd_busy bypass term when BYPASS=1).
- No combinational path from rd_addr to res_accept.

## Test plan
- Reset then read: reset low 3 cycles with all addresses driven → rd_data all 0, pending_count 0, wb_error 0. Write x5=0xDEADBEEF without reservation → wb_error=1 and persists; x5 reads 0xDEADBEEF next cycle.
- Reserve/writeback: reserve x3 → res_accept=1, next cycle rd_busy=1 on a port reading x3, pending_count=1. Writeback x3=0x12345678 → with BYPASS=1, same-cycle rd_data=0x12345678 and rd_busy=0; next cycle pending_count=0.
- WAW refusal: reserve x7, then reserve x7 again → res_accept=0, pending_count stays 1. Same cycle as writeback x7 → res_accept=1, busy stays, pending_count stays 1, x7 holds new data.
- x0 handling: reserve x0 → accepted, pending_count 0. Writeback x0=0xFFFFFFFF → x0 reads 0, wb_error unchanged.
- Fill: reserve x1..x31 consecutively → pending_count reaches 31. Reserve x31 again → refused. Writeback all in reverse order → count reaches 0 with no wrap.
- Async reset mid-flight: 4 reservations outstanding, pull reset low between edges → busy and pending_count 0 immediately (before the next edge). Release reset, then writeback x2 → wb_error=1.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// Register file with a per-register busy scoreboard for hazard detection.
// Read ports are combinational, with an optional writeback bypass; destinations are tracked through reservations.
module scoreboard_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  res_valid,
  input  logic [AW-1:0]         res_rd,
  output logic                  res_accept,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [AW:0]           pending_count,
  output logic                  wb_error
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wb_we, res_set, cnt_dec;

  assign wb_we   = wb_valid & (wb_rd != '0);
  assign res_set = res_accept & (res_rd != '0);
  assign cnt_dec = wb_we & busy_q[wb_rd];

  // A busy destination is acceptable only when it retires in the same cycle.
  assign res_accept = reset & res_valid &
                      ((res_rd == '0) | ~busy_q[res_rd] | (wb_valid & (wb_rd == res_rd)));

  // Set after clear so that a same-cycle reservation wins over the retiring writeback.
  always_comb begin
    busy_d = busy_q;
    if (wb_we)   busy_d[wb_rd]  = 1'b0;
    if (res_set) busy_d[res_rd] = 1'b1;
    cnt_d = cnt_q + (AW+1)'(res_set) - (AW+1)'(cnt_dec);
    err_d = err_q | (wb_we & ~busy_q[wb_rd]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wb_we) mem_q[wb_rd] <= wb_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pending_count = cnt_q;
  assign wb_error      = err_q;

  for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] data_c;
    logic            busy_c;

    assign addr = rd_addr[g*AW +: AW];
    assign hit  = BYP & wb_valid & (wb_rd == addr);

    // Outputs are forced quiet while reset is held, even if writeback inputs toggle.
    always_comb begin
      data_c = '0;
      busy_c = 1'b0;
      if (reset && (addr != '0)) begin
        data_c = hit ? wb_data : mem_q[addr];
        busy_c = busy_q[addr] & ~(hit & ~(res_accept & (res_rd == addr)));
      end
    end

    assign rd_data[g*XLEN +: XLEN] = data_c;
    assign rd_busy[g]              = busy_c;
  end

endmodule
